// File: rtl/line_memory.sv
// line_memory: 128-bit line backing store for the cache, with fixed-latency pipelined reads,
// post-reset init sweep of a deterministic pattern, and saturating read/write traffic counters.
`default_nettype none

module line_memory #(
    parameter int          LATENCY     = 5,
    parameter int          DEPTH_LINES = 512,
    parameter logic [31:0] INIT_XOR    = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  addr_in,
    input  logic         rden,
    input  logic         wren,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         data_out_valid,
    output logic         mem_ready,
    output logic [15:0]  read_count,
    output logic [15:0]  write_count
);

    localparam int IDX_W = $clog2(DEPTH_LINES);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               init_wr;
    logic [127:0]       init_line;
    logic [IDX_W-1:0]   idx;
    logic               acc_rd, acc_wr;

    logic [127:0]       mem_q  [DEPTH_LINES];
    logic [127:0]       pipe_q [LATENCY];
    logic [LATENCY-1:0] vld_q;

    logic [127:0]       data_out_q;
    logic               data_out_valid_q;
    logic [15:0]        read_count_q, write_count_q;

    // Offset and high address bits are don't-care: lines alias above the index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_in[31:4+IDX_W], addr_in[3:0]};

    assign idx    = addr_in[4+IDX_W-1:4];
    assign acc_rd = rden && (state_q == ST_RUN);
    assign acc_wr = wren && (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        init_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == IDX_W'(DEPTH_LINES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        init_line = '0;
        for (int k = 0; k < 4; k++) begin
            init_line[32*k +: 32] = 32'({ptr_q, 2'(k)}) ^ INIT_XOR;
        end
    end

    // Read samples the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr) begin
                mem_q[ptr_q] <= init_line;
            end else if (acc_wr) begin
                mem_q[idx] <= data_in;
            end
        end
        pipe_q[0] <= mem_q[idx];
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            vld_q            <= {vld_q[LATENCY-2:0], acc_rd};
            data_out_valid_q <= vld_q[LATENCY-1];
            if (vld_q[LATENCY-1]) begin
                data_out_q <= pipe_q[LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            if (acc_rd && (read_count_q != 16'hFFFF)) begin
                read_count_q <= read_count_q + 16'd1;
            end
            if (acc_wr && (write_count_q != 16'hFFFF)) begin
                write_count_q <= write_count_q + 16'd1;
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign mem_ready      = (state_q == ST_RUN);
    assign read_count     = read_count_q;
    assign write_count    = write_count_q;

endmodule

`default_nettype wire

// File: tb/tb_line_memory.sv
// tb_line_memory: scoreboard bench for line_memory; expected lines come from a bench-side
// memory model and are queued with their due cycle when each read is issued.
`default_nettype none

module tb_line_memory;

    localparam int LAT   = 5;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr_in;
    logic         rden, wren;
    logic [127:0] data_in;
    logic [127:0] data_out;
    logic         data_out_valid;
    logic         mem_ready;
    logic [15:0]  read_count, write_count;

    line_memory #(
        .LATENCY     (LAT),
        .DEPTH_LINES (DEPTH),
        .INIT_XOR    (32'hDEADBEEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .addr_in        (addr_in),
        .rden           (rden),
        .wren           (wren),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .mem_ready      (mem_ready),
        .read_count     (read_count),
        .write_count    (write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [127:0] data;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] model [DEPTH];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int           spurious = 0;
    int           n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input int i);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = (i*4 + k) ^ 32'hDEADBEEF;
        return l;
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = init_line(i);
    endtask

    always @(posedge clk) begin
        #1;
        if (data_out_valid) begin
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rd_data", data_out, e.data);
                chk("rd_latency", 128'(cyc), 128'(e.due));
            end else begin
                spurious++;
            end
        end
    end

    // One request per cycle; expectation comes from the model before any same-cycle write.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [127:0] d, input logic expect_rd);
        int li;
        @(negedge clk);
        rden = rd; wren = wr; addr_in = a; data_in = d;
        li = int'(a[12:4]);
        if (rd && expect_rd) sb_q.push_back('{due: cyc + 1 + LAT, data: model[li]});
        if (wr) model[li] = d;
        @(posedge clk);
        #1;
        rden = 1'b0; wren = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #2;
        chk("drain_empty", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic wait_ready(input logic rd_during, output int cnt);
        cnt = 0;
        rden = rd_during;
        addr_in = 32'h30;
        while (!mem_ready && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        rden = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rden = 1'b0; wren = 1'b0; addr_in = '0; data_in = '0;
        model_init();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(mem_ready), 128'(0));
        chk("rst_valid", 128'(data_out_valid), 128'(0));
        chk("rst_data", data_out, 128'(0));
        chk("rst_rcnt", 128'(read_count), 128'(0));
        chk("rst_wcnt", 128'(write_count), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        wait_ready(1'b0, n);
        chk("init_cycles", 128'(n), 128'(512));

        issue(1'b1, 1'b0, 32'h30, '0, 1'b1);
        drain();
        chk("line3_value", data_out, 128'hDEADBEE0_DEADBEE1_DEADBEE2_DEADBEE3);
        chk("rcnt_1", 128'(read_count), 128'(1));

        issue(1'b0, 1'b1, 32'h40, {4{32'h11111111}}, 1'b1);
        issue(1'b1, 1'b0, 32'h2040, '0, 1'b1);
        drain();
        chk("alias_value", data_out, {4{32'h11111111}});
        chk("wcnt_1", 128'(write_count), 128'(1));
        chk("rcnt_2", 128'(read_count), 128'(2));

        issue(1'b1, 1'b1, 32'h50, {4{32'hCAFEF00D}}, 1'b1);
        issue(1'b1, 1'b0, 32'h50, '0, 1'b1);
        drain();
        chk("wcnt_2", 128'(write_count), 128'(2));

        for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, 32'(i) << 4, '0, 1'b1);
        drain();
        chk("rcnt_9", 128'(read_count), 128'(9));

        for (int i = 0; i < 65531; i++) issue(1'b1, 1'b0, 32'($urandom_range(0, 511)) << 4, '0, 1'b1);
        drain();
        chk("rcnt_sat", 128'(read_count), 128'(16'hFFFF));

        // Reset lands two edges after a read is issued; that read must never complete.
        issue(1'b1, 1'b0, 32'h10, '0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_data", data_out, 128'(0));
        chk("midrst_rcnt", 128'(read_count), 128'(0));
        chk("midrst_wcnt", 128'(write_count), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        model_init();
        wait_ready(1'b1, n);
        chk("reinit_cycles", 128'(n), 128'(512));
        chk("init_rd_ignored", 128'(read_count), 128'(0));

        issue(1'b1, 1'b0, 32'h40, '0, 1'b1);
        issue(1'b1, 1'b0, 32'h50, '0, 1'b1);
        drain();
        chk("reinit_line5", data_out, init_line(5));
        repeat (LAT + 3) @(posedge clk);
        #1;
        chk("no_spurious", 128'(spurious), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
